// File: rtl/fnd_monitor.sv
// fnd_monitor: receive-side decoder for the multiplexed 4-digit FND bus.
// Debounces each digit select, decodes fonts to BCD and rebuilds the number.
module fnd_monitor #(
  parameter int SETTLE  = 4,
  parameter int TIMEOUT = 1_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  fndFont,
  input  logic [3:0]  fndCom,
  output logic [15:0] bcd,
  output logic [13:0] value,
  output logic [3:0]  dp,
  output logic [3:0]  blank,
  output logic        err,
  output logic        valid,
  output logic        frame_done
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [7:0]    SET_LAST = 8'(SETTLE - 1);
  localparam logic [TW-1:0] TO_MAX   = TW'(TIMEOUT);
  localparam logic [TW-1:0] TO_HIT   = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_HELD
  } state_t;

  logic [3:0]      r_com;
  logic [7:0]      r_font;
  state_t          r_state;
  state_t          w_state_nxt;
  logic [7:0]      r_cnt;
  logic [7:0]      w_cnt_nxt;
  logic [3:0]      r_pat;
  logic [3:0]      w_pat_nxt;
  logic            w_cap;
  logic            w_go;
  logic            w_one;
  logic            w_same;
  logic [1:0]      w_slot;

  logic [3:0]      w_dnib;
  logic            w_dblk;
  logic            w_dinv;

  logic [3:0][3:0] r_nib;
  logic [3:0]      r_dps;
  logic [3:0]      r_blk;
  logic [3:0]      r_inv;
  logic [3:0]      r_seen;
  logic [3:0]      w_seen_nxt;
  logic            w_done;

  logic [TW-1:0]   r_to;
  logic            w_stale;

  logic [13:0]     w_value;
  logic            w_err;

  // Register the bus once; everything downstream uses these copies.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_com  <= 4'hF;
      r_font <= 8'hFF;
    end else begin
      r_com  <= fndCom;
      r_font <= fndFont;
    end
  end

  // Classify the registered select: exactly one low bit, and which slot.
  always_comb begin
    w_one  = 1'b1;
    w_slot = 2'd0;
    case (r_com)
      4'b1110: w_slot = 2'd0;
      4'b1101: w_slot = 2'd1;
      4'b1011: w_slot = 2'd2;
      4'b0111: w_slot = 2'd3;
      default: w_one  = 1'b0;
    endcase
  end

  assign w_same = (r_com == r_pat);

  // Debounce FSM next state: count stable cycles, capture once per slot visit.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_pat_nxt   = r_pat;
    w_cap       = 1'b0;
    w_go        = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        w_cnt_nxt = 8'd0;
        if (w_one) w_go = 1'b1;
      end
      ST_SETTLE: begin
        if (!w_one) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = 8'd0;
        end else if (!w_same) begin
          w_go = 1'b1;
        end else if (r_cnt == SET_LAST) begin
          w_cap       = 1'b1;
          w_cnt_nxt   = r_cnt + 8'd1;
          w_state_nxt = ST_HELD;
        end else begin
          w_cnt_nxt = r_cnt + 8'd1;
        end
      end
      ST_HELD: begin
        if (!w_one) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = 8'd0;
        end else if (!w_same) begin
          w_go = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = 8'd0;
      end
    endcase
    if (w_go) begin
      w_pat_nxt = r_com;
      w_cnt_nxt = 8'd1;
      if (SETTLE == 1) begin
        w_cap       = 1'b1;
        w_state_nxt = ST_HELD;
      end else begin
        w_state_nxt = ST_SETTLE;
      end
    end
  end

  // Debounce FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= 8'd0;
      r_pat   <= 4'hF;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_pat   <= w_pat_nxt;
    end
  end

  // Segment pattern back to a BCD nibble; unknown shapes flag invalid.
  always_comb begin
    w_dnib = 4'hF;
    w_dblk = 1'b0;
    w_dinv = 1'b0;
    case (r_font[6:0])
      7'h40: w_dnib = 4'd0;
      7'h79: w_dnib = 4'd1;
      7'h24: w_dnib = 4'd2;
      7'h30: w_dnib = 4'd3;
      7'h19: w_dnib = 4'd4;
      7'h12: w_dnib = 4'd5;
      7'h02: w_dnib = 4'd6;
      7'h78: w_dnib = 4'd7;
      7'h00: w_dnib = 4'd8;
      7'h10: w_dnib = 4'd9;
      7'h7F: begin
        w_dnib = 4'd0;
        w_dblk = 1'b1;
      end
      default: w_dinv = 1'b1;
    endcase
  end

  // Slot store: a capture overwrites whatever the slot held.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_nib <= '0;
      r_dps <= 4'h0;
      r_blk <= 4'h0;
      r_inv <= 4'h0;
    end else if (w_cap) begin
      r_nib[w_slot] <= w_dnib;
      r_dps[w_slot] <= ~r_font[7];
      r_blk[w_slot] <= w_dblk;
      r_inv[w_slot] <= w_dinv;
    end
  end

  assign w_done  = (r_seen == 4'hF);
  assign w_stale = !w_cap && (r_to >= TO_HIT);

  // Seen mask: emptied on frame load or staleness, a capture always lands.
  always_comb begin
    w_seen_nxt = w_done ? 4'h0 : r_seen;
    if (w_cap) begin
      w_seen_nxt[w_slot] = 1'b1;
    end else if (w_stale) begin
      w_seen_nxt = 4'h0;
    end
  end

  // Seen mask register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_seen <= 4'h0;
    else       r_seen <= w_seen_nxt;
  end

  // Cycles since the last capture, saturating at the stale limit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_to <= '0;
    end else if (w_cap) begin
      r_to <= '0;
    end else if (r_to != TO_MAX) begin
      r_to <= r_to + TW'(1);
    end
  end

  assign w_err   = |r_inv;
  assign w_value = 14'(r_nib[3]) * 14'd1000
                 + 14'(r_nib[2]) * 14'd100
                 + 14'(r_nib[1]) * 14'd10
                 + 14'(r_nib[0]);

  // Output frame: load on completion, drop valid when the bus goes quiet.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bcd        <= 16'h0;
      value      <= 14'h0;
      dp         <= 4'h0;
      blank      <= 4'h0;
      err        <= 1'b0;
      valid      <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= w_done;
      if (w_done) begin
        bcd   <= r_nib;
        value <= w_err ? 14'h0 : w_value;
        dp    <= r_dps;
        blank <= r_blk;
        err   <= w_err;
        valid <= 1'b1;
      end else if (w_stale) begin
        valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fnd_monitor.sv
// tb_fnd_monitor: directed and random scans checked against a frame-level
// model of the FND bus decoder.
module tb_fnd_monitor;

  localparam int SET = 4;
  localparam int TO  = 100;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  fndFont = 8'hFF;
  logic [3:0]  fndCom = 4'hF;
  logic [15:0] bcd;
  logic [13:0] value;
  logic [3:0]  dp;
  logic [3:0]  blank;
  logic        err;
  logic        valid;
  logic        frame_done;

  always #5 clk = ~clk;

  fnd_monitor #(.SETTLE(SET), .TIMEOUT(TO)) dut (
    .clk(clk),
    .reset(rst),
    .fndFont(fndFont),
    .fndCom(fndCom),
    .bcd(bcd),
    .value(value),
    .dp(dp),
    .blank(blank),
    .err(err),
    .valid(valid),
    .frame_done(frame_done)
  );

  int total = 0;
  int bad = 0;
  int shown = 0;
  bit chk_on = 1'b0;
  int fd_cnt = 0;

  logic [7:0] seg_of [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                              8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
  int pw [4] = '{1, 10, 100, 1000};

  // model state: raw input history and per-slot contents
  logic [3:0]  m_prev_com;
  logic [7:0]  m_prev_font;
  int          m_run;
  int          m_to;
  int          m_nib [4];
  bit          m_dp [4];
  bit          m_blk [4];
  bit          m_inv [4];
  bit [3:0]    m_seen;
  logic [15:0] e_bcd;
  int          e_val;
  logic [3:0]  e_dp;
  logic [3:0]  e_blank;
  bit          e_err;
  bit          e_valid;
  bit          e_fd;
  int          mk, mn, msum;
  bit          mb, mi, merr;

  function automatic bit one_low(input logic [3:0] c);
    return $countones(c) == 3;
  endfunction

  function automatic void decode(input logic [6:0] s, output int nib,
                                 output bit blk, output bit inv);
    logic [7:0] t;
    blk = 1'b0;
    inv = 1'b1;
    nib = 15;
    if (s == 7'h7F) begin
      blk = 1'b1;
      inv = 1'b0;
      nib = 0;
    end else begin
      for (int d = 0; d < 10; d++) begin
        t = seg_of[d];
        if (s == t[6:0]) begin
          nib = d;
          inv = 1'b0;
        end
      end
    end
  endfunction

  // Model: a slot is captured once its select has been sampled SET times
  // in a row; the frame is published one edge after the fourth slot lands.
  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      m_prev_com = 4'hF;
      m_prev_font = 8'hFF;
      m_run = 0;
      m_to = 0;
      m_seen = 4'h0;
      for (int k = 0; k < 4; k++) begin
        m_nib[k] = 0; m_dp[k] = 0; m_blk[k] = 0; m_inv[k] = 0;
      end
      e_bcd = 16'h0; e_val = 0; e_dp = 4'h0; e_blank = 4'h0;
      e_err = 0; e_valid = 0; e_fd = 0;
    end else begin
      e_fd = 0;
      if (m_seen == 4'hF) begin
        merr = 0;
        msum = 0;
        for (int k = 0; k < 4; k++) begin
          mn = m_inv[k] ? 15 : m_nib[k];
          e_bcd[4*k +: 4] = 4'(mn);
          e_dp[k] = m_dp[k];
          e_blank[k] = m_blk[k];
          if (m_inv[k]) merr = 1;
          msum += mn * pw[k];
        end
        e_err = merr;
        e_val = merr ? 0 : msum;
        e_valid = 1;
        e_fd = 1;
        m_seen = 4'h0;
      end
      if (one_low(m_prev_com) && m_run == SET) begin
        mk = 0;
        for (int k = 0; k < 4; k++) if (!m_prev_com[k]) mk = k;
        decode(m_prev_font[6:0], mn, mb, mi);
        m_nib[mk] = mn;
        m_blk[mk] = mb;
        m_inv[mk] = mi;
        m_dp[mk] = !m_prev_font[7];
        m_seen[mk] = 1'b1;
        m_to = 0;
      end else begin
        if (m_to < TO) m_to++;
        if (m_to >= TO) begin
          e_valid = 0;
          m_seen = 4'h0;
        end
      end
      if (fndCom == m_prev_com) m_run++;
      else m_run = 1;
      m_prev_com = fndCom;
      m_prev_font = fndFont;
    end
  end

  // Compare process: every cycle once reset has been applied.
  initial forever begin
    @(negedge clk);
    if (frame_done === 1'b1) fd_cnt++;
    if (chk_on) begin
      total++;
      if ({bcd, value, dp, blank, err, valid, frame_done} !==
          {e_bcd, 14'(e_val), e_dp, e_blank, e_err, e_valid, e_fd}) begin
        bad++;
        if (shown < 20) begin
          shown++;
          $display("FAIL cycle t=%0t bcd %h/%h value %0d/%0d dp %b/%b blank %b/%b err %b/%b valid %b/%b fd %b/%b",
                   $time, bcd, e_bcd, value, e_val, dp, e_dp, blank, e_blank,
                   err, e_err, valid, e_valid, frame_done, e_fd);
        end
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic drive(input logic [3:0] c, input logic [7:0] f, input int n);
    fndCom = c;
    fndFont = f;
    tick(n);
  endtask

  task automatic frame(input logic [7:0] f3, input logic [7:0] f2,
                       input logic [7:0] f1, input logic [7:0] f0, input int dw);
    drive(4'b0111, f3, dw);
    drive(4'b1011, f2, dw);
    drive(4'b1101, f1, dw);
    drive(4'b1110, f0, dw);
  endtask

  int f0;
  int n;
  int r;
  logic [7:0] rf;

  initial begin
    #1 rst = 1'b1;
    tick(3);
    chk_on = 1'b1;
    chk("rst_bcd", int'(bcd), 0);
    chk("rst_value", int'(value), 0);
    chk("rst_flags", int'({dp, blank, err, valid, frame_done}), 0);
    rst = 1'b0;
    tick(5);

    // 1234, 16 cycles per digit
    f0 = fd_cnt;
    frame(8'hF9, 8'hA4, 8'hB0, 8'h99, 16);
    chk("t1_fd_count", fd_cnt - f0, 1);
    chk("t1_bcd", int'(bcd), 'h1234);
    chk("t1_value", int'(value), 1234);
    chk("t1_err", int'(err), 0);
    chk("t1_valid", int'(valid), 1);
    chk("t1_model_bcd", int'(e_bcd), 'h1234);

    // "0." with three blanks
    frame(8'hFF, 8'hFF, 8'hFF, 8'h40, 16);
    chk("t2_bcd", int'(bcd), 0);
    chk("t2_blank", int'(blank), 'hE);
    chk("t2_dp", int'(dp), 'h1);
    chk("t2_value", int'(value), 0);

    // 3-cycle glitch on the tens select between d1 and d0
    f0 = fd_cnt;
    drive(4'b0111, 8'h92, 16);
    drive(4'b1011, 8'h82, 16);
    drive(4'b1101, 8'hF8, 16);
    drive(4'b1101, 8'h90, 3);
    drive(4'b1110, 8'h80, 16);
    chk("t3_fd_count", fd_cnt - f0, 1);
    chk("t3_bcd", int'(bcd), 'h5678);
    chk("t3_value", int'(value), 5678);

    // two-low and no-select held: nothing captured
    f0 = fd_cnt;
    drive(4'b0011, 8'hC0, 50);
    drive(4'b1111, 8'hC0, 50);
    chk("t4_no_frame", fd_cnt - f0, 0);
    frame(8'h90, 8'hC0, 8'hF9, 8'hA4, 16);
    chk("t4_fd_count", fd_cnt - f0, 1);
    chk("t4_bcd", int'(bcd), 'h9012);
    chk("t4_valid", int'(valid), 1);

    // undecodable pattern on the hundreds digit
    frame(8'hF9, 8'h6D, 8'hB0, 8'h99, 16);
    chk("t5_err", int'(err), 1);
    chk("t5_bcd", int'(bcd), 'h1F34);
    chk("t5_value", int'(value), 0);

    // staleness: valid drops TO cycles after the last capture
    drive(4'b0111, 8'hF9, 16);
    drive(4'b1011, 8'hA4, 16);
    drive(4'b1101, 8'hB0, 16);
    fndCom = 4'b1110;
    fndFont = 8'h99;
    n = 0;
    while (frame_done !== 1'b1 && n < 40) begin
      tick(1);
      n++;
    end
    chk("t6_fd_seen", int'(frame_done === 1'b1), 1);
    fndCom = 4'hF;
    n = 0;
    while (valid === 1'b1 && n < 300) begin
      tick(1);
      n++;
    end
    chk("t6_stale_cycles", n, TO - 1);
    chk("t6_bcd_held", int'(bcd), 'h1234);

    // reset in the middle of a frame
    frame(8'h92, 8'h82, 8'hF8, 8'h80, 16);
    drive(4'b0111, 8'hF9, 16);
    drive(4'b1011, 8'hA4, 16);
    rst = 1'b1;
    #1;
    chk("t7_rst_bcd", int'(bcd), 0);
    chk("t7_rst_value", int'(value), 0);
    chk("t7_rst_valid", int'(valid), 0);
    tick(2);
    rst = 1'b0;
    f0 = fd_cnt;
    drive(4'b1101, 8'hB0, 16);
    drive(4'b1110, 8'h99, 16);
    drive(4'hF, 8'hFF, 4);
    chk("t7_partial_no_frame", fd_cnt - f0, 0);
    chk("t7_partial_valid", int'(valid), 0);
    frame(8'hF9, 8'hA4, 8'hB0, 8'h99, 16);
    chk("t7_fd_count", fd_cnt - f0, 1);
    chk("t7_bcd", int'(bcd), 'h1234);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 99);
      if (r < 70) begin
        n = $urandom_range(0, 19);
        if (n < 17) begin
          rf = seg_of[$urandom_range(0, 9)];
          rf[7] = 1'($urandom_range(0, 1));
        end else if (n < 18) begin
          rf = {1'($urandom_range(0, 1)), 7'h7F};
        end else begin
          rf = 8'($urandom);
        end
        fndCom = 4'b1111;
        fndCom[$urandom_range(0, 3)] = 1'b0;
        fndFont = rf;
        tick($urandom_range(1, 10));
      end else if (r < 85) begin
        drive(4'($urandom), 8'($urandom), $urandom_range(1, 6));
      end else if (r < 98) begin
        drive(4'hF, 8'hFF, ($urandom_range(0, 3) == 0) ?
              $urandom_range(90, 130) : $urandom_range(1, 30));
      end else begin
        rst = 1'b1;
        tick($urandom_range(1, 2));
        rst = 1'b0;
      end
    end
    drive(4'hF, 8'hFF, 5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #3_000_000;
    bad++;
    $display("FAIL watchdog: got timeout want finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
